// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// Fixed-latency mult/multu/div/divu unit owning the HI/LO registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic              res_wr_q, res_wr_d;

  logic        is_signed, a_neg, b_neg, div_by_zero;
  logic [31:0] mag_a, mag_b, divisor, uquot, urem, quot, rem;
  logic [63:0] ext_a, ext_b, prod;

  // Divide on magnitudes and fix signs afterwards; this also makes
  // 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
  always_comb begin
    is_signed   = (op == OP_MULT) || (op == OP_DIV);
    a_neg       = is_signed & a[31];
    b_neg       = is_signed & b[31];
    mag_a       = a_neg ? (32'd0 - a) : a;
    mag_b       = b_neg ? (32'd0 - b) : b;
    div_by_zero = (b == 32'd0);
    divisor     = div_by_zero ? 32'd1 : mag_b;
    uquot       = mag_a / divisor;
    urem        = mag_a % divisor;
    quot        = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    rem         = a_neg ? (32'd0 - urem) : urem;
    ext_a       = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b       = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod        = ext_a * ext_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          if (op[1]) begin
            cnt_d    = DIV_LAT;
            res_hi_d = rem;
            res_lo_d = quot;
            res_wr_d = ~div_by_zero;
          end else begin
            cnt_d    = MULT_LAT;
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            res_wr_d = 1'b1;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      ST_BUSY: begin
        // Requests arriving here are ignored; the hazard unit stalls on busy.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_BUSY);

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning cycles from accepted mult/multu start to HI/LO update.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning cycles from accepted div/divu start to HI/LO update.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage request to begin the operation in op.
REQ-006 SHALL have port op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have ports a, b  input  32 each  operands (rs, rt); a is the dividend, b the divisor.
REQ-008 SHALL have ports mthi, mtlo  input  1 each  direct write of wdata to HI / LO.
REQ-009 SHALL have port wdata  input  32  data for mthi/mtlo.
REQ-010 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have port busy  output  1  operation in flight; the hazard unit stalls on start|busy.

Function
REQ-012 SHALL implement two states: IDLE, BUSY.
REQ-013 In IDLE, start=1 at edge N SHALL latch operands, compute the result, load the counter with MULT_CYCLES or DIV_CYCLES per op[1], and enter BUSY.
REQ-014 busy SHALL be 1 after edge N through edge N+L (L = selected latency), i.e. exactly L cycles.
REQ-015 At edge N+L, hi/lo SHALL take the pending result and busy SHALL fall in the same edge; hi/lo SHALL not change during BUSY.
REQ-016 mult: {hi,lo} = signed 64-bit product of a and b; multu: unsigned 64-bit product.
REQ-017 div: lo = signed quotient truncated toward zero, hi = remainder with the dividend's sign; divu: unsigned quotient/remainder.
REQ-018 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-019 Division with b=0 SHALL still run DIV_CYCLES and assert busy, but SHALL leave hi and lo unchanged at completion.
REQ-020 start, mthi and mtlo asserted while busy=1 SHALL be ignored, with no change to state, counter or pending result.
REQ-021 In IDLE, mthi SHALL write hi and mtlo SHALL write lo at the edge; both may write in one cycle.
REQ-022 In IDLE, start together with mthi/mtlo SHALL give priority to start; the mt write is dropped.
REQ-023 The counter SHALL be wide enough for max(MULT_CYCLES, DIV_CYCLES) and SHALL never wrap; a latency of 1 SHALL give a one-cycle busy.
REQ-024 op SHALL be sampled only on accepted start; later changes to a, b or op SHALL not affect the result in flight.

Reset
REQ-025 reset=1 SHALL immediately, without a clock, set hi=0, lo=0, busy=0, counter=0 and state=IDLE.
REQ-026 reset mid-operation SHALL abort the operation; no pending result is written after release.
REQ-027 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 A shared package mdu_pkg SHALL hold the op encodings, the IDLE/BUSY state encoding and the default latency constants, for reuse by the control decoder and the hazard unit.
REQ-029 The block SHALL have no sub-module; datapath arithmetic is inline and the state machine plus counter live in one module.

Verification
REQ-030 mult a=0xFFFFFFFE (-2), b=3 at edge N -> busy high for 5 cycles; after edge N+5: hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-031 div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1.
REQ-032 mthi 0x12345678 and mtlo 0x9ABCDEF0 in the same IDLE cycle -> both registers are updated; then div b=0 -> busy for 10 cycles and hi/lo keep those values.
REQ-033 mult accepted, then at cycle 2 start div plus mthi 0xDEAD -> both ignored; mult result appears at cycle 5 and busy drops.
REQ-034 Assert reset asynchronously at cycle 3 of a div -> busy, hi and lo go to 0 before the next edge; no write follows; a new mult after release completes normally.
REQ-035 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; back-to-back mult issued the cycle busy falls is accepted.
